spi_tx_queue: RTL and testbench

Byte queue and burst sequencer sitting directly upstream of `SPI_Controller_With_Single_CS`. It buffers bytes written by the system side in a FIFO and groups them into chip-select bursts of up to `MAX_BYTES_PER_CS` bytes. It drives the controller's `i_TX_Count` / `i_TX_Byte` / `i_TX_DV` interface and paces each byte on `o_TX_Ready`. This lets software-side producers push bytes without tracking controller handshake timing.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_byte_fifo.sv | 58 +++++
 rtl/spi_tx_queue.sv | 125 ++++++++++++
 tb/tb_spi_tx_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transmit queue and its byte FIFO.
package spi_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StGap, StWaitRdy} txq_state_e;

  typedef logic [7:0] spi_byte_t;

  function automatic int unsigned min_cnt(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous byte FIFO: power-of-two depth, wrapping pointers, registered level/full/empty.
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned LvlW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  spi_byte_t       data_i,
  input  logic            pop_i,
  output spi_byte_t       head_o,
  output logic [LvlW-1:0] level_o,
  output logic            full_o,
  output logic            empty_o
);

  spi_byte_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/spi_tx_queue.sv
// Byte queue and chip-select burst sequencer feeding a single-CS SPI controller.
// Optional sticky overflow flag enabled by defining SPI_TXQ_OVF_EN.
module spi_tx_queue
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned MAX_BYTES_PER_CS = 1,
  parameter int unsigned CNT_W            = $clog2(MAX_BYTES_PER_CS + 1),
  localparam int unsigned LvlW            = $clog2(DEPTH + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Wr_DV,
  input  logic [7:0]       i_Wr_Byte,
  output logic             o_Full,
  output logic             o_Empty,
  output logic [LvlW-1:0]  o_Level,
  output logic             o_Busy,
  output logic [CNT_W-1:0] o_TX_Count,
  output logic [7:0]       o_TX_Byte,
  output logic             o_TX_DV,
`ifdef SPI_TXQ_OVF_EN
  output logic             o_Overflow,
  input  logic             i_Ovf_Clr,
`endif
  input  logic             i_TX_Ready
);

  txq_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_rem_q, burst_rem_d;
  logic [CNT_W-1:0] count_q, count_d;
  spi_byte_t        byte_q, byte_d;
  spi_byte_t        head;
  logic             push, pop;

  assign push = i_Wr_DV && !o_Full;

  spi_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .push_i  (push),
    .data_i  (i_Wr_Byte),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (o_Level),
    .full_o  (o_Full),
    .empty_o (o_Empty)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= StIdle;
      burst_rem_q <= '0;
      count_q     <= '0;
      byte_q      <= '0;
    end else begin
      state_q     <= state_d;
      burst_rem_q <= burst_rem_d;
      count_q     <= count_d;
      byte_q      <= byte_d;
    end
  end

  // The byte is latched on entry to ISSUE so it is valid alongside the DV pulse.
  always_comb begin
    state_d     = state_q;
    burst_rem_d = burst_rem_q;
    count_d     = count_q;
    byte_d      = byte_q;
    unique case (state_q)
      StIdle: begin
        if (!o_Empty && i_TX_Ready) begin
          burst_rem_d = CNT_W'(min_cnt(32'(o_Level), MAX_BYTES_PER_CS));
          count_d     = CNT_W'(min_cnt(32'(o_Level), MAX_BYTES_PER_CS));
          byte_d      = head;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        burst_rem_d = burst_rem_q - CNT_W'(1);
        state_d     = StGap;
      end
      StGap: state_d = StWaitRdy;
      StWaitRdy: begin
        if (i_TX_Ready) begin
          if (burst_rem_q != '0) begin
            byte_d  = head;
            state_d = StIssue;
          end else begin
            count_d = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_TX_DV    = (state_q == StIssue);
    pop        = (state_q == StIssue);
    o_Busy     = (state_q != StIdle);
    o_TX_Count = count_q;
    o_TX_Byte  = byte_q;
  end

`ifdef SPI_TXQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      ovf_q <= 1'b0;
    end else if (i_Wr_DV && o_Full) begin
      ovf_q <= 1'b1;
    end else if (i_Ovf_Clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign o_Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_spi_tx_queue.sv
// Directed bench for spi_tx_queue with a simple controller ready model.
module tb_spi_tx_queue;

  localparam int unsigned Depth = 16;
  localparam int unsigned MaxB  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_dv = 1'b0;
  logic [7:0] wr_byte = '0;
  logic       full, empty, busy, tx_dv;
  logic [4:0] level;
  logic [2:0] tx_cnt;
  logic [7:0] tx_byte;
  logic       ready;
  logic       hold = 1'b0;
  logic [1:0] ctl_cnt;
`ifdef SPI_TXQ_OVF_EN
  logic       ovf;
  logic       ovf_clr = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] rx_b[$];
  logic [2:0] rx_c[$];
  logic       prev_rdy = 1'b0;

  always #5 clk = ~clk;

  spi_tx_queue #(
    .DEPTH            (Depth),
    .MAX_BYTES_PER_CS (MaxB)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Wr_DV    (wr_dv),
    .i_Wr_Byte  (wr_byte),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Level    (level),
    .o_Busy     (busy),
    .o_TX_Count (tx_cnt),
    .o_TX_Byte  (tx_byte),
    .o_TX_DV    (tx_dv),
`ifdef SPI_TXQ_OVF_EN
    .o_Overflow (ovf),
    .i_Ovf_Clr  (ovf_clr),
`endif
    .i_TX_Ready (ready)
  );

  // Controller model: ready drops the cycle after DV and stays low for two cycles.
  always @(posedge clk or posedge rst) begin
    if (rst)              ctl_cnt <= 2'd0;
    else if (tx_dv)       ctl_cnt <= 2'd2;
    else if (ctl_cnt != 0) ctl_cnt <= ctl_cnt - 2'd1;
  end
  assign ready = !hold && (ctl_cnt == 2'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && tx_dv) begin
      rx_b.push_back(tx_byte);
      rx_c.push_back(tx_cnt);
      chk("dv_after_ready", {31'd0, prev_rdy}, 32'd1);
    end
    prev_rdy = ready;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    wr_dv   = 1'b1;
    wr_byte = b;
    @(posedge clk);
    #1;
    wr_dv   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_b.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    if (rx_b.size() < n) chk("rx_timeout", rx_b.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || !empty) && k < budget) begin
      cyc(1);
      k++;
    end
    if (busy || !empty) chk("idle_timeout", {30'd0, busy, empty}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] wr;
    logic [7:0] exp_byte;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h01, 8'h01, 3'd4};
    vecs[1] = '{8'h02, 8'h02, 3'd4};
    vecs[2] = '{8'h03, 8'h03, 3'd4};
    vecs[3] = '{8'h04, 8'h04, 3'd4};
    vecs[4] = '{8'h05, 8'h05, 3'd2};
    vecs[5] = '{8'h06, 8'h06, 3'd2};

    // Reset state
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dv", tx_dv, 0);
    chk("rst_cnt", tx_cnt, 0);
    chk("rst_byte", tx_byte, 0);
`ifdef SPI_TXQ_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    cyc(50);
    chk("rst_no_dv", rx_b.size(), 0);

    // Single byte: DV two cycles after the write
    wr(8'hA5);
    chk("lat_n1_dv", tx_dv, 0);
    chk("lat_n1_level", level, 1);
    cyc(1);
    chk("lat_n2_dv", tx_dv, 1);
    chk("lat_n2_byte", tx_byte, 8'hA5);
    chk("lat_n2_cnt", tx_cnt, 1);
    cyc(1);
    chk("lat_pulse_end", tx_dv, 0);
    wait_idle(50);
    chk("single_cnt_idle", tx_cnt, 0);
    chk("single_rx", rx_b.size(), 1);
    rx_b.delete();
    rx_c.delete();

    // Burst grouping from the table
    hold = 1'b1;
    foreach (vecs[i]) wr(vecs[i].wr);
    chk("grp_level", level, 6);
    hold = 1'b0;
    wait_rx(6, 200);
    for (int i = 0; i < 6; i++) begin
      if (i < rx_b.size()) begin
        chk($sformatf("grp_byte%0d", i), rx_b[i], vecs[i].exp_byte);
        chk($sformatf("grp_cnt%0d", i), rx_c[i], vecs[i].exp_cnt);
      end
    end
    wait_idle(50);
    rx_b.delete();
    rx_c.delete();

    // Full and overflow
    hold = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
    chk("full_flag", full, 1);
    chk("full_level", level, 16);
    wr(8'hEE);
    chk("full_drop_level", level, 16);
`ifdef SPI_TXQ_OVF_EN
    chk("ovf_set", ovf, 1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
`endif
    hold = 1'b0;
    wait_rx(16, 400);
    chk("full_rx_n", rx_b.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < rx_b.size()) begin
        chk($sformatf("full_byte%0d", i), rx_b[i], 8'h10 + 8'(i));
        chk($sformatf("full_cnt%0d", i), rx_c[i], 4);
      end
    end
    wait_idle(50);
    rx_b.delete();
    rx_c.delete();

    // Pointer wrap: 5 rounds of 8 writes, draining in between
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 8; i++) wr(8'h40 + 8'(r * 8 + i));
      wait_idle(200);
    end
    chk("wrap_rx_n", rx_b.size(), 40);
    for (int i = 0; i < 40; i++) begin
      if (i < rx_b.size()) chk($sformatf("wrap_byte%0d", i), rx_b[i], 8'h40 + 8'(i));
    end
    rx_b.delete();
    rx_c.delete();

    // Reset mid-burst while waiting for ready
    hold = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'h31 + 8'(i));
    hold = 1'b0;
    wait_rx(1, 50);
    hold = 1'b1;
    cyc(2);
    chk("mid_busy", busy, 1);
    chk("mid_level", level, 3);
    chk("mid_cnt", tx_cnt, 4);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_empty", empty, 1);
    chk("mrst_level", level, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_dv", tx_dv, 0);
    chk("mrst_cnt", tx_cnt, 0);
    chk("mrst_byte", tx_byte, 0);
    chk("mrst_full", full, 0);
    cyc(2);
    rst  = 1'b0;
    hold = 1'b0;
    rx_b.delete();
    rx_c.delete();
    cyc(50);
    chk("mrst_no_dv", rx_b.size(), 0);
    wr(8'h77);
    wait_rx(1, 20);
    if (rx_b.size() > 0) begin
      chk("mrst_new_byte", rx_b[0], 8'h77);
      chk("mrst_new_cnt", rx_c[0], 1);
    end
    wait_idle(50);
    chk("mrst_only_one", rx_b.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
